laser_cover: RTL
================

# laser_cover

Parametrised two-circle coverage search engine for the laser-targeting datapath. It loads a frame of N_PTS target points serially, then searches the full grid for two circle centres of radius R. The goal is to maximise the number of points inside at least one circle. It reports both centres, the covered count and a one-cycle DONE, then returns to load the next frame. It generalises the fixed 40-point / 16x16 / radius-4 engine with configurable sizes, a valid-qualified load, iterative refinement and a result count.

## Interface

- N_PTS, 40, points per frame (≥2)
- CW, 4, coordinate width; grid is 2^CW x 2^CW
- R, 4, circle radius (integer, 1..2^CW-1)
- MAX_PASS, 8, maximum refinement passes (≥1)
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- IN_VALID  in  1  X/Y carry a point this cycle
- X  in  CW  point x coordinate
- Y  in  CW  point y coordinate
- C1X, C1Y  out  CW each  centre of circle 1
- C2X, C2Y  out  CW each  centre of circle 2
- COUNT  out  $clog2(N_PTS+1)  points covered by the reported pair
- DONE  out  1  result valid, one-cycle pulse

## Operation

- Coverage test for point p and centre c: (px-cx)^2 + (py-cy)^2 <= R^2.
  - Differences are signed CW+1 bits; the sum is unsigned 2CW+3 bits.
  - The boundary counts as covered.
- Union count: the number of points covered by circle 1 or circle 2. It is computed combinationally over all N_PTS points for one candidate per cycle.
- States:
  - LOAD
    - Each cycle with IN_VALID=1 writes (X,Y) to point slot idx, then increments idx.
    - Cycles with IN_VALID=0 are ignored.
    - Accepting slot N_PTS-1 moves to SWP1.
  - SWP1
    - Candidate (cx,cy) scans y outer 0..2^CW-1 and x inner 0..2^CW-1, one candidate per cycle.
    - The candidate is evaluated as circle 1, with circle 2 fixed at the current C2.
    - The best candidate is updated only when the union count is strictly greater, so the earliest candidate wins ties.
    - The best count is cleared at sweep start.
  - CMT1: the current C1 takes the best SWP1 candidate.
  - SWP2: same as SWP1, with the candidate evaluated as circle 2 and C1 fixed.
  - CMT2
    - Commits C2 and increments the pass counter.
    - Goes to OUT if the SWP2 best count is not greater than the previous pass's count (initially 0) or if the pass counter reaches MAX_PASS. Otherwise it returns to SWP1.
  - OUT: DONE=1 and output registers load; next state is LOAD with idx=0.
- At the first SWP1 of each frame, the working centres are initialised to (2^(CW-1), 2^(CW-1)).
- IN_VALID is ignored in every state except LOAD.
- The point store is overwritten by each new frame and is not cleared.

## Timing

- Reset values:
  - State LOAD, idx=0, pass counter 0.
  - C1X, C1Y, C2X, C2Y, COUNT all 0.
  - DONE 0.
- Each sweep lasts exactly 2^(2CW) cycles, and each commit state lasts 1 cycle. One pass therefore takes 2*(2^(2CW)+1) cycles: 514 at the defaults.
- If the last point is accepted at edge k, SWP1 begins in cycle k+1. DONE is high in cycle k+1+P*514 at the defaults, where P is the number of passes executed.
- Outputs change only on the edge that enters OUT. They hold through the next frame's load and search until the next OUT.
- DONE is high for exactly one cycle per frame.
- The earliest first IN_VALID of the next frame is the cycle after DONE.
- RST mid-load or mid-search aborts immediately: all reset values apply and the partial frame is discarded.

## Test plan

- Default parameters, all 40 points at (3,3), contiguous IN_VALID:
  - C1=(1,0), C2=(0,0), COUNT=40.
  - 2 passes; DONE at k+1029.
- 20 points at (2,2) and 20 at (13,13):
  - C1=(0,0), C2=(13,9), COUNT=40.
  - DONE at k+1029.
- Same frame as the first test with IN_VALID deasserted every other cycle, and X/Y toggling while IN_VALID=0:
  - Identical result.
  - DONE timing shifts only by the load stretch.
- RST asserted mid-SWP2, then a full new frame loaded:
  - During reset: all outputs 0, DONE 0.
  - The new frame's result is correct, with no residue from the aborted frame.
- Two back-to-back frames:
  - Frame-1 outputs hold until frame-2's DONE.
  - DONE pulses exactly twice, each for one cycle.
- Variant N_PTS=8, CW=3, R=2, 8 points at (6,6):
  - C1=(6,4), C2=(0,0), COUNT=8.
  - Each sweep takes 64 cycles and each pass 130 cycles.

Source files
------------

// File: rtl/laser_cover.sv
// laser_cover: two-circle coverage search engine.
// Loads a frame of N_PTS points, then alternately sweeps the full grid for
// circle 1 and circle 2 until the covered count stops improving or the pass
// limit is hit. It then reports both centres and the count with a DONE pulse.
module laser_cover #(
   parameter int N_PTS    = 40,
   parameter int CW       = 4,
   parameter int R        = 4,
   parameter int MAX_PASS = 8
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         IN_VALID,
   input  logic [CW-1:0]                X,
   input  logic [CW-1:0]                Y,
   output logic [CW-1:0]                C1X,
   output logic [CW-1:0]                C1Y,
   output logic [CW-1:0]                C2X,
   output logic [CW-1:0]                C2Y,
   output logic [$clog2(N_PTS+1)-1:0]   COUNT,
   output logic                         DONE
);

   localparam int CNTW  = $clog2(N_PTS + 1);
   localparam int IDXW  = $clog2(N_PTS);
   localparam int PASSW = $clog2(MAX_PASS + 1);
   localparam int CANDW = 2 * CW;
   localparam int SUMW  = 2 * CW + 3;

   localparam logic [SUMW-1:0]  R_SQ     = SUMW'(R * R);
   localparam logic [CW-1:0]    MID      = CW'(1 << (CW - 1));
   localparam logic [IDXW-1:0]  LAST     = IDXW'(N_PTS - 1);
   localparam logic [PASSW-1:0] PASS_MAX = PASSW'(MAX_PASS);

   typedef enum logic [2:0] {
      S_LOAD,
      S_SWP1,
      S_CMT1,
      S_SWP2,
      S_CMT2,
      S_OUT
   } state_t;

   state_t           state_q;
   logic [IDXW-1:0]  idx_q;
   logic [PASSW-1:0] pass_q;
   logic [CNTW-1:0]  prev_cnt_q;
   logic [CANDW-1:0] cand_q;
   logic [CNTW-1:0]  best_cnt_q;
   logic [CW-1:0]    best_x_q, best_y_q;
   logic [CW-1:0]    w1x_q, w1y_q, w2x_q, w2y_q;
   logic [CW-1:0]    c1x_q, c1y_q, c2x_q, c2y_q;
   logic [CNTW-1:0]  cnt_q;
   logic             done_q;

   logic [CW-1:0]    px_q [N_PTS];
   logic [CW-1:0]    py_q [N_PTS];

   logic [CW-1:0]    cand_x, cand_y, fix_x, fix_y;
   logic [CNTW-1:0]  union_cnt;
   logic [PASSW-1:0] pass_d;

   // Inclusive circle test with signed (CW+1)-bit differences.
   function automatic logic covers(input logic [CW-1:0] ax, input logic [CW-1:0] ay,
                                   input logic [CW-1:0] bx, input logic [CW-1:0] by);
      logic signed [CW:0]   dx, dy;
      logic signed [SUMW-1:0] ex, ey;
      logic [SUMW-1:0]      sq;
      dx = $signed({1'b0, ax}) - $signed({1'b0, bx});
      dy = $signed({1'b0, ay}) - $signed({1'b0, by});
      ex = {{(CW + 2){dx[CW]}}, dx};
      ey = {{(CW + 2){dy[CW]}}, dy};
      sq = $unsigned(ex * ex) + $unsigned(ey * ey);
      return (sq <= R_SQ);
   endfunction

   // Candidate index scans x fastest, y slowest; the other circle stays fixed.
   assign cand_x = cand_q[CW-1:0];
   assign cand_y = cand_q[CANDW-1:CW];
   assign fix_x  = (state_q == S_SWP1) ? w2x_q : w1x_q;
   assign fix_y  = (state_q == S_SWP1) ? w2y_q : w1y_q;
   assign pass_d = pass_q + PASSW'(1);

   // Union coverage of candidate plus fixed circle over the whole frame.
   always_comb begin
      union_cnt = '0;
      for (int unsigned i = 0; i < N_PTS; i++) begin
         if (covers(px_q[i], py_q[i], cand_x, cand_y) ||
             covers(px_q[i], py_q[i], fix_x, fix_y))
            union_cnt = union_cnt + CNTW'(1);
      end
   end

   // Point store: written only while loading, never cleared.
   always_ff @(posedge CLK) begin
      if (state_q == S_LOAD && IN_VALID) begin
         px_q[idx_q] <= X;
         py_q[idx_q] <= Y;
      end
   end

   // Control FSM with sweep bookkeeping and registered result outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= S_LOAD;
         idx_q      <= '0;
         pass_q     <= '0;
         prev_cnt_q <= '0;
         cand_q     <= '0;
         best_cnt_q <= '0;
         best_x_q   <= '0;
         best_y_q   <= '0;
         w1x_q      <= '0;
         w1y_q      <= '0;
         w2x_q      <= '0;
         w2y_q      <= '0;
         c1x_q      <= '0;
         c1y_q      <= '0;
         c2x_q      <= '0;
         c2y_q      <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_LOAD: begin
               if (IN_VALID) begin
                  if (idx_q == LAST) begin
                     idx_q      <= '0;
                     state_q    <= S_SWP1;
                     w1x_q      <= MID;
                     w1y_q      <= MID;
                     w2x_q      <= MID;
                     w2y_q      <= MID;
                     pass_q     <= '0;
                     prev_cnt_q <= '0;
                     cand_q     <= '0;
                     best_cnt_q <= '0;
                  end else begin
                     idx_q <= idx_q + IDXW'(1);
                  end
               end
            end
            S_SWP1, S_SWP2: begin
               // Strictly-greater update keeps the earliest candidate on ties.
               if (union_cnt > best_cnt_q) begin
                  best_cnt_q <= union_cnt;
                  best_x_q   <= cand_x;
                  best_y_q   <= cand_y;
               end
               cand_q <= cand_q + CANDW'(1);
               if (cand_q == '1)
                  state_q <= (state_q == S_SWP1) ? S_CMT1 : S_CMT2;
            end
            S_CMT1: begin
               w1x_q      <= best_x_q;
               w1y_q      <= best_y_q;
               best_cnt_q <= '0;
               cand_q     <= '0;
               state_q    <= S_SWP2;
            end
            S_CMT2: begin
               w2x_q      <= best_x_q;
               w2y_q      <= best_y_q;
               pass_q     <= pass_d;
               prev_cnt_q <= best_cnt_q;
               if (best_cnt_q <= prev_cnt_q || pass_d == PASS_MAX) begin
                  state_q <= S_OUT;
                  c1x_q   <= w1x_q;
                  c1y_q   <= w1y_q;
                  c2x_q   <= best_x_q;
                  c2y_q   <= best_y_q;
                  cnt_q   <= best_cnt_q;
                  done_q  <= 1'b1;
               end else begin
                  state_q    <= S_SWP1;
                  best_cnt_q <= '0;
                  cand_q     <= '0;
               end
            end
            S_OUT: begin
               state_q <= S_LOAD;
               idx_q   <= '0;
            end
            default: state_q <= S_LOAD;
         endcase
      end
   end

   assign C1X   = c1x_q;
   assign C1Y   = c1y_q;
   assign C2X   = c2x_q;
   assign C2Y   = c2y_q;
   assign COUNT = cnt_q;
   assign DONE  = done_q;

endmodule
